trace_capture_buffer: RTL and testbench
=======================================

# trace_capture_buffer

Single-clock, parametrised successor of the stream trace buffer: captures a TRACE_WIDTH-bit sample stream into a DEPTH-entry circular memory, with masked multi-source triggering, a programmable post-trigger window, and a streaming (FIFO) mode with overflow accounting. It sits between the FPGA trace sources and the system-side ready/valid readout path. Unlike its predecessor, it does not need a separate FPGA clock domain.

## Interface
- TRACE_WIDTH, 32, sample width
- DEPTH, 1024, memory entries; must be a power of two and at least 4
- NUM_TRIG, 4, trigger source count
- ADDR_WIDTH, $clog2(DEPTH), pointer width
- CLK_I  in  1  single clock
- RST_I  in  1  reset, asynchronous, active-high
- CFG_VALID_I  in  1  configuration strobe; CFG_READY_O is tied to 1, so every strobe is accepted
- CFG_READY_O  out  1  constant 1
- CFG_MODE_I  in  1  0 = TRACE, 1 = STREAM
- CFG_POST_I  in  ADDR_WIDTH  post-trigger sample count
- CFG_TRIG_MASK_I  in  NUM_TRIG  enabled trigger sources
- CFG_TRIG_AND_I  in  1  1 = all enabled sources must be high, 0 = any enabled source
- TRACE_VALID_I  in  1  sample strobe
- TRACE_I  in  TRACE_WIDTH  sample
- TRIG_I  in  NUM_TRIG  trigger sources
- DATA_VALID_O  out  1  readout valid
- DATA_READY_I  in  1  readout ready
- DATA_O  out  TRACE_WIDTH  readout sample
- STATE_O  out  3  current state encoding
- TRIG_O  out  1  one-cycle pulse on a qualified trigger
- FILL_O  out  ADDR_WIDTH+1  number of samples held in memory (excludes the output register)
- OVERFLOW_CNT_O  out  16  dropped samples in STREAM mode; saturates at 0xFFFF

## Operation
- States: IDLE, ARMED, POST, DONE, STREAM. On reset the block enters IDLE.
- Configuration accept:
  - Accepted in any state.
  - Clears the pointers, FILL_O, OVERFLOW_CNT_O and the output register.
  - Latches all CFG_* fields.
  - Next state: ARMED if CFG_MODE_I = 0, STREAM if CFG_MODE_I = 1.
- Trigger hit:
  - Definition: TRACE_VALID_I & (mask != 0) & (AND ? &(TRIG_I | ~mask) : |(TRIG_I & mask)).
  - A trigger is only evaluated on valid samples.
- ARMED (TRACE mode):
  - Every valid sample is written at the write pointer.
  - When FILL = DEPTH, the read pointer advances with each write: the oldest sample is overwritten and FILL stays at DEPTH.
  - On a hit: the hit sample is written, TRIG_O pulses, and the post counter loads CFG_POST.
  - Next state on a hit: POST, or DONE if CFG_POST = 0.
- POST:
  - Each valid sample is written with the same overwrite rule and decrements the counter.
  - The write that takes the counter to 0 moves the state to DONE.
  - Further hits are ignored.
- DONE:
  - Writes stop.
  - Memory drains oldest-first into the output register.
  - When both FILL = 0 and the output register is empty, the state returns to IDLE.
- STREAM:
  - A valid sample is written if FILL < DEPTH.
  - Otherwise the sample is dropped and OVERFLOW_CNT_O increments.
  - Readout runs concurrently. Hits pulse TRIG_O only.
  - The block stays in STREAM until reconfigured or reset.
- DATA_VALID_O is 0 in IDLE, ARMED and POST.

## Timing
- Reset values: DATA_VALID_O = 0, DATA_O = 0, TRIG_O = 0, FILL_O = 0, OVERFLOW_CNT_O = 0, STATE_O = IDLE, CFG_READY_O = 1.
- Memory: synchronous read with one cycle of latency, followed by a registered output stage.
  - First DATA_VALID_O comes 2 cycles after entering DONE, or 2 cycles after the first STREAM write.
- Handshake:
  - DATA_O is held stable while DATA_VALID_O & !DATA_READY_I.
  - One sample transfers per cycle when DATA_READY_I is held high (sustained throughput of 1/cycle).
- FULL decision uses the registered FILL. A same-cycle pop does not free a slot for a push.
- Simultaneous push and pop: FILL is unchanged.
- Pointer wrap-around is modulo DEPTH through natural ADDR_WIDTH overflow.
- Simultaneous configuration accept and sample: the configuration wins and the sample is discarded.
- Asynchronous reset mid-operation: everything returns to IDLE immediately. Memory contents are don't-care.
- TRIG_O asserts in the cycle after the hit sample is presented.

## Structure
- Shared package TCB_PKG contains:
  - tcb_state_e (IDLE = 0, ARMED = 1, POST = 2, DONE = 3, STREAM = 4)
  - tcb_mode_e
  - TCB_OVF_WIDTH = 16
- Sub-module tcb_sdp_ram:
  - simple dual-port RAM, parametrised by width and depth
  - synchronous read
  - infers block RAM
- The FSM, pointers, trigger evaluation and output stage live in trace_capture_buffer.

## Test plan
Bench parameters: DEPTH = 8, TRACE_WIDTH = 8, NUM_TRIG = 4.
- TRACE, mask = 0001, OR, POST = 2; samples 0..19 with a hit on sample 12; DATA_READY_I = 1 → readout is 7..14 in order (exactly 8 beats), then STATE_O returns to IDLE.
- TRACE, mask = 0110, AND; TRIG_I = 0100 then 0110 on sample 5, POST = 0 → a single TRIG_O pulse, DONE entered, readout is 0..5.
- STREAM, DATA_READY_I = 0, 11 valid samples → FILL_O = 8, OVERFLOW_CNT_O = 3; then DATA_READY_I = 1 → readout 0..7 with no gaps.
- STREAM with continuous push and pop at FILL = 8 → no overflow increment (pop drains the output register, then a slot opens), ordering preserved.
- Readout back-pressure: DATA_READY_I toggled 1/0 → DATA_O held stable while stalled; no sample lost or duplicated.
- RST_I asserted while in POST → all outputs return to reset values asynchronously; after reconfiguration, capture restarts cleanly.

Source files
------------

// File: rtl/tcb_pkg.sv
// Shared types and constants for the trace capture buffer.
package tcb_pkg;

    localparam int unsigned TCB_OVF_WIDTH   = 16;
    localparam int unsigned TCB_STATE_WIDTH = 3;

    typedef enum logic [TCB_STATE_WIDTH-1:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        POST   = 3'd2,
        DONE   = 3'd3,
        STREAM = 3'd4
    } tcb_state_e;

    typedef enum logic {
        MODE_TRACE  = 1'b0,
        MODE_STREAM = 1'b1
    } tcb_mode_e;

endpackage

// File: rtl/tcb_sdp_ram.sv
// Simple dual-port RAM with one write port and one synchronous read port.
module tcb_sdp_ram #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // No reset so the array maps onto block RAM; read data holds when rd_en is low.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/trace_capture_buffer.sv
// Circular trace capture with masked triggering, post-trigger window and a
// streaming FIFO mode, read out through a registered ready/valid stage.
module trace_capture_buffer
    import tcb_pkg::*;
#(
    parameter int unsigned TRACE_WIDTH = 32,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned NUM_TRIG    = 4,
    parameter int unsigned ADDR_WIDTH  = $clog2(DEPTH)
) (
    input  logic                       CLK_I,
    input  logic                       RST_I,
    input  logic                       CFG_VALID_I,
    output logic                       CFG_READY_O,
    input  logic                       CFG_MODE_I,
    input  logic [ADDR_WIDTH-1:0]      CFG_POST_I,
    input  logic [NUM_TRIG-1:0]        CFG_TRIG_MASK_I,
    input  logic                       CFG_TRIG_AND_I,
    input  logic                       TRACE_VALID_I,
    input  logic [TRACE_WIDTH-1:0]     TRACE_I,
    input  logic [NUM_TRIG-1:0]        TRIG_I,
    output logic                       DATA_VALID_O,
    input  logic                       DATA_READY_I,
    output logic [TRACE_WIDTH-1:0]     DATA_O,
    output logic [TCB_STATE_WIDTH-1:0] STATE_O,
    output logic                       TRIG_O,
    output logic [ADDR_WIDTH:0]        FILL_O,
    output logic [TCB_OVF_WIDTH-1:0]   OVERFLOW_CNT_O
);

    localparam int unsigned FILL_WIDTH = ADDR_WIDTH + 1;
    localparam logic [FILL_WIDTH-1:0] FILL_FULL = FILL_WIDTH'(DEPTH);

    tcb_state_e                 state_q, state_d;
    logic                       trig_q, trig_d;
    logic [ADDR_WIDTH-1:0]      cfg_post_q;
    logic [NUM_TRIG-1:0]        cfg_mask_q;
    logic                       cfg_and_q;
    logic [ADDR_WIDTH-1:0]      wr_ptr_q, rd_ptr_q;
    logic [FILL_WIDTH-1:0]      fill_q;
    logic [TCB_OVF_WIDTH-1:0]   ovf_q;
    logic [ADDR_WIDTH-1:0]      post_cnt_q;
    logic                       rd_pending_q;
    logic                       out_valid_q;
    logic [TRACE_WIDTH-1:0]     out_data_q;
    logic [TRACE_WIDTH-1:0]     ram_rd_data;

    logic      cfg_accept, hit, full, empty, capturing, draining;
    logic      wr_en, overwrite, drop, pop, out_load;
    logic      post_load, post_dec;
    tcb_mode_e cfg_mode;

    assign cfg_accept = CFG_VALID_I;
    assign cfg_mode   = tcb_mode_e'(CFG_MODE_I);

    // Qualified trigger: AND ignores disabled sources, OR looks only at enabled ones.
    assign hit = TRACE_VALID_I && (cfg_mask_q != '0) &&
                 (cfg_and_q ? (&(TRIG_I | ~cfg_mask_q)) : (|(TRIG_I & cfg_mask_q)));

    assign full      = (fill_q == FILL_FULL);
    assign empty     = (fill_q == '0);
    assign capturing = (state_q == ARMED) || (state_q == POST);
    assign draining  = (state_q == DONE) || (state_q == STREAM);

    assign wr_en     = !cfg_accept && TRACE_VALID_I &&
                       (capturing || ((state_q == STREAM) && !full));
    assign overwrite = wr_en && capturing && full;
    assign drop      = !cfg_accept && TRACE_VALID_I && (state_q == STREAM) && full;

    // The RAM output acts as a holding stage; it advances into the output register when that frees up.
    assign out_load = rd_pending_q && (!out_valid_q || DATA_READY_I);
    assign pop      = !cfg_accept && draining && !empty && DATA_READY_I &&
                      (!rd_pending_q || out_load);

    always_comb begin
        state_d   = state_q;
        trig_d    = 1'b0;
        post_load = 1'b0;
        post_dec  = 1'b0;
        if (cfg_accept) begin
            state_d = (cfg_mode == MODE_STREAM) ? STREAM : ARMED;
        end else begin
            unique case (state_q)
                ARMED: begin
                    if (hit) begin
                        trig_d    = 1'b1;
                        post_load = 1'b1;
                        state_d   = (cfg_post_q == '0) ? DONE : POST;
                    end
                end
                POST: begin
                    if (TRACE_VALID_I) begin
                        post_dec = 1'b1;
                        if (post_cnt_q == ADDR_WIDTH'(1)) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (empty && !rd_pending_q && !out_valid_q) begin
                        state_d = IDLE;
                    end
                end
                STREAM: begin
                    trig_d = hit;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q <= IDLE;
            trig_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            trig_q  <= trig_d;
        end
    end

    // Configuration, pointers, fill/overflow accounting and the output stage.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            cfg_post_q   <= '0;
            cfg_mask_q   <= '0;
            cfg_and_q    <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fill_q       <= '0;
            ovf_q        <= '0;
            post_cnt_q   <= '0;
            rd_pending_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
        end else if (cfg_accept) begin
            cfg_post_q   <= CFG_POST_I;
            cfg_mask_q   <= CFG_TRIG_MASK_I;
            cfg_and_q    <= CFG_TRIG_AND_I;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fill_q       <= '0;
            ovf_q        <= '0;
            post_cnt_q   <= '0;
            rd_pending_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
            end
            if (pop || overwrite) begin
                rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
            end
            if (wr_en && !overwrite && !pop) begin
                fill_q <= fill_q + FILL_WIDTH'(1);
            end else if (pop && !wr_en) begin
                fill_q <= fill_q - FILL_WIDTH'(1);
            end
            if (drop && (ovf_q != '1)) begin
                ovf_q <= ovf_q + TCB_OVF_WIDTH'(1);
            end
            if (post_load) begin
                post_cnt_q <= cfg_post_q;
            end else if (post_dec) begin
                post_cnt_q <= post_cnt_q - ADDR_WIDTH'(1);
            end
            rd_pending_q <= pop || (rd_pending_q && !out_load);
            if (out_load) begin
                out_valid_q <= 1'b1;
                out_data_q  <= ram_rd_data;
            end else if (DATA_READY_I) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    tcb_sdp_ram #(
        .WIDTH      (TRACE_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (CLK_I),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (TRACE_I),
        .rd_en   (pop),
        .rd_addr (rd_ptr_q),
        .rd_data (ram_rd_data)
    );

    assign CFG_READY_O    = 1'b1;
    assign DATA_VALID_O   = out_valid_q;
    assign DATA_O         = out_data_q;
    assign STATE_O        = state_q;
    assign TRIG_O         = trig_q;
    assign FILL_O         = fill_q;
    assign OVERFLOW_CNT_O = ovf_q;

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Directed self-checking bench for trace_capture_buffer (DEPTH 8, 8-bit samples, 4 triggers).
module tb_trace_capture_buffer;

    localparam int unsigned TW    = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned NT    = 4;
    localparam int unsigned AW    = 3;

    localparam logic [31:0] S_IDLE   = 32'd0;
    localparam logic [31:0] S_ARMED  = 32'd1;
    localparam logic [31:0] S_POST   = 32'd2;
    localparam logic [31:0] S_DONE   = 32'd3;
    localparam logic [31:0] S_STREAM = 32'd4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_valid, cfg_ready, cfg_mode, cfg_and;
    logic [AW-1:0] cfg_post;
    logic [NT-1:0] cfg_mask;
    logic          trace_valid;
    logic [TW-1:0] trace;
    logic [NT-1:0] trig;
    logic          data_valid, data_ready;
    logic [TW-1:0] data_o;
    logic [2:0]    state_o;
    logic          trig_o;
    logic [AW:0]   fill_o;
    logic [15:0]   ovf_o;

    int            vectors     = 0;
    int            miscompares = 0;
    int            beats       = 0;
    int            trig_seen   = 0;
    logic [TW-1:0] exp_q[$];
    logic          stall_prev  = 1'b0;
    logic [TW-1:0] held        = '0;

    always #5 clk = ~clk;

    trace_capture_buffer #(
        .TRACE_WIDTH (TW),
        .DEPTH       (DEPTH),
        .NUM_TRIG    (NT),
        .ADDR_WIDTH  (AW)
    ) dut (
        .CLK_I           (clk),
        .RST_I           (rst),
        .CFG_VALID_I     (cfg_valid),
        .CFG_READY_O     (cfg_ready),
        .CFG_MODE_I      (cfg_mode),
        .CFG_POST_I      (cfg_post),
        .CFG_TRIG_MASK_I (cfg_mask),
        .CFG_TRIG_AND_I  (cfg_and),
        .TRACE_VALID_I   (trace_valid),
        .TRACE_I         (trace),
        .TRIG_I          (trig),
        .DATA_VALID_O    (data_valid),
        .DATA_READY_I    (data_ready),
        .DATA_O          (data_o),
        .STATE_O         (state_o),
        .TRIG_O          (trig_o),
        .FILL_O          (fill_o),
        .OVERFLOW_CNT_O  (ovf_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expected);
        vectors++;
        assert (obs === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expected);
        end
    endtask

    // One clock: score the beat or stall presented now, advance, sample #1 after the edge.
    task automatic step();
        if (stall_prev) begin
            check("hold_valid", 32'(data_valid), 32'd1);
            check("hold_data", 32'(data_o), 32'(held));
        end
        if (data_valid && data_ready) begin
            check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("beat_data", 32'(data_o), 32'(exp_q.pop_front()));
            end
            beats++;
        end
        stall_prev = data_valid && !data_ready;
        held       = data_o;
        @(posedge clk);
        #1;
        if (trig_o) trig_seen++;
    endtask

    task automatic push(input logic [TW-1:0] v, input logic [NT-1:0] t);
        trace_valid = 1'b1;
        trace       = v;
        trig        = t;
        step();
        trace_valid = 1'b0;
        trig        = '0;
    endtask

    task automatic configure(input logic mode, input logic [AW-1:0] post,
                             input logic [NT-1:0] mask, input logic and_mode);
        cfg_valid = 1'b1;
        cfg_mode  = mode;
        cfg_post  = post;
        cfg_mask  = mask;
        cfg_and   = and_mode;
        step();
        cfg_valid  = 1'b0;
        stall_prev = 1'b0;
        beats      = 0;
        trig_seen  = 0;
    endtask

    task automatic drain(input string tag);
        for (int n = 0; n < 64 && exp_q.size() != 0; n++) step();
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        cfg_valid = 1'b0; cfg_mode = 1'b0; cfg_post = '0; cfg_mask = '0; cfg_and = 1'b0;
        trace_valid = 1'b0; trace = '0; trig = '0; data_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 32'(state_o), S_IDLE);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_data", 32'(data_o), 32'd0);
        check("rst_trig", 32'(trig_o), 32'd0);
        check("rst_fill", 32'(fill_o), 32'd0);
        check("rst_ovf", 32'(ovf_o), 32'd0);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        rst = 1'b0;
        step();

        // Trace, OR on source 0, post 2, hit on sample 12: last 8 samples 7..14 retained
        data_ready = 1'b1;
        configure(1'b0, 3'd2, 4'b0001, 1'b0);
        check("t1_armed", 32'(state_o), S_ARMED);
        for (int i = 7; i <= 14; i++) exp_q.push_back(TW'(i));
        for (int i = 0; i < 20; i++) begin
            push(TW'(i), (i == 12) ? 4'b0001 : 4'b0000);
            if (i == 12) begin
                check("t1_trig", 32'(trig_o), 32'd1);
                check("t1_post", 32'(state_o), S_POST);
            end
            if (i == 14) begin
                check("t1_done", 32'(state_o), S_DONE);
                check("t1_fill", 32'(fill_o), 32'd8);
            end
        end
        drain("t1");
        step(); step();
        check("t1_beats", 32'(beats), 32'd8);
        check("t1_trig_count", 32'(trig_seen), 32'd1);
        check("t1_idle", 32'(state_o), S_IDLE);
        check("t1_idle_valid", 32'(data_valid), 32'd0);

        // Trace, AND over sources 1 and 2, post 0: hit only when both are high
        configure(1'b0, 3'd0, 4'b0110, 1'b1);
        for (int i = 0; i <= 5; i++) exp_q.push_back(TW'(i));
        for (int i = 0; i <= 5; i++) begin
            push(TW'(i), (i == 5) ? 4'b0110 : 4'b0100);
            if (i == 4) check("t2_no_trig", 32'(trig_o), 32'd0);
        end
        check("t2_trig", 32'(trig_o), 32'd1);
        check("t2_done", 32'(state_o), S_DONE);
        push(8'h66, 4'b0110);
        push(8'h77, 4'b0110);
        drain("t2");
        step(); step();
        check("t2_beats", 32'(beats), 32'd6);
        check("t2_trig_count", 32'(trig_seen), 32'd1);
        check("t2_idle", 32'(state_o), S_IDLE);

        // Stream with readout stalled: 8 kept, 3 dropped, then gapless readout
        data_ready = 1'b0;
        configure(1'b1, 3'd0, 4'b0000, 1'b0);
        check("t3_stream", 32'(state_o), S_STREAM);
        for (int i = 0; i < 11; i++) push(TW'(i), 4'b0000);
        check("t3_fill", 32'(fill_o), 32'd8);
        check("t3_ovf", 32'(ovf_o), 32'd3);
        check("t3_no_valid", 32'(data_valid), 32'd0);
        for (int i = 0; i < 8; i++) exp_q.push_back(TW'(i));
        data_ready = 1'b1;
        step(); step();
        for (int i = 0; i < 8; i++) begin
            check("t3_gapless", 32'(data_valid), 32'd1);
            step();
        end
        check("t3_drained", 32'(exp_q.size()), 32'd0);
        check("t3_fill_empty", 32'(fill_o), 32'd0);
        check("t3_state", 32'(state_o), S_STREAM);

        // Stream, concurrent push and pop starting from full
        data_ready = 1'b0;
        configure(1'b1, 3'd0, 4'b0001, 1'b0);
        for (int i = 0; i < 18; i++) exp_q.push_back(TW'(i));
        for (int i = 0; i < 8; i++) push(TW'(i), 4'b0000);
        check("t4_full", 32'(fill_o), 32'd8);
        data_ready = 1'b1;
        step();
        check("t4_first_pop", 32'(fill_o), 32'd7);
        for (int i = 8; i < 18; i++) begin
            push(TW'(i), (i == 13) ? 4'b0001 : 4'b0000);
            if (i == 13) check("t4_stream_trig", 32'(trig_o), 32'd1);
        end
        check("t4_fill", 32'(fill_o), 32'd7);
        check("t4_ovf", 32'(ovf_o), 32'd0);
        drain("t4");
        check("t4_beats", 32'(beats), 32'd18);
        check("t4_trig_count", 32'(trig_seen), 32'd1);

        // Back-pressure: ready toggling, output must hold while stalled
        data_ready = 1'b0;
        configure(1'b1, 3'd0, 4'b0000, 1'b0);
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(TW'(8'h40 + i));
            push(TW'(8'h40 + i), 4'b0000);
        end
        for (int i = 0; i < 24; i++) begin
            data_ready = i[0];
            step();
        end
        data_ready = 1'b1;
        drain("t5");
        step();
        check("t5_beats", 32'(beats), 32'd6);

        // Asynchronous reset while in POST, then a clean restart
        configure(1'b0, 3'd3, 4'b0001, 1'b0);
        push(8'h00, 4'b0000);
        push(8'h01, 4'b0000);
        push(8'h02, 4'b0001);
        check("t6_post", 32'(state_o), S_POST);
        check("t6_trig", 32'(trig_o), 32'd1);
        check("t6_fill", 32'(fill_o), 32'd3);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_state", 32'(state_o), S_IDLE);
        check("t6_rst_trig", 32'(trig_o), 32'd0);
        check("t6_rst_fill", 32'(fill_o), 32'd0);
        check("t6_rst_valid", 32'(data_valid), 32'd0);
        check("t6_rst_data", 32'(data_o), 32'd0);
        check("t6_rst_ovf", 32'(ovf_o), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        stall_prev = 1'b0;
        trace_valid = 1'b1;
        trace = 8'hEE;
        trig = 4'b0001;
        configure(1'b0, 3'd1, 4'b0001, 1'b0);
        trace_valid = 1'b0;
        trig = '0;
        check("t6_cfg_wins_fill", 32'(fill_o), 32'd0);
        check("t6_cfg_wins_trig", 32'(trig_o), 32'd0);
        check("t6_armed", 32'(state_o), S_ARMED);
        for (int i = 10; i <= 13; i++) exp_q.push_back(TW'(i));
        for (int i = 10; i <= 13; i++) push(TW'(i), (i == 12) ? 4'b0001 : 4'b0000);
        check("t6_done", 32'(state_o), S_DONE);
        drain("t6");
        step(); step();
        check("t6_beats", 32'(beats), 32'd4);
        check("t6_idle", 32'(state_o), S_IDLE);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
